// File: rtl/bclk_train_seq.sv
// -----------------------------------------------------------------------------
// bclk_train_seq
// Training sequencer for the DDR3 BCLK training IOD lane. After TRAIN_START it
// sweeps the RX delay line from tap 0 up to TAP_MAX (or until the IOD reports
// out-of-range). At each tap it clears the eye-monitor flags, waits for the
// line to settle, observes EARLY/LATE for a sample window and records the
// longest contiguous run of passing taps. It then reloads the delay line and
// steps it to the centre of that window.
//
// Ports
//   FAB_CLK                    fabric clock (same as IOD RX_CLK)
//   ARST_N                     asynchronous active-low reset
//   TRAIN_START                one-cycle start request (honoured in IDLE/DONE/ERR)
//   TRAIN_BUSY                 sequence in progress
//   TRAIN_DONE / TRAIN_ERR     sticky success / failure flags
//   TAP_CENTER [7:0]           final tap loaded into the delay line
//   WINDOW_WIDTH [8:0]         best window length in taps
//   DELAY_LINE_MOVE_0          one-cycle step pulse
//   DELAY_LINE_DIRECTION_0     step direction, constant 1 (increment)
//   DELAY_LINE_LOAD_0          one-cycle reload-to-tap-0 pulse
//   EYE_MONITOR_CLEAR_FLAGS_0  one-cycle flag clear pulse
//   EYE_MONITOR_EARLY_0/LATE_0 eye-monitor flags (already in FAB_CLK domain)
//   DELAY_LINE_OUT_OF_RANGE_0  delay line cannot move further
//   RX_DATA_0 [7:0]            deserialised lane data
//
// Build option: define BCLK_TRAIN_RXDATA_CHECK_EN to also fail a tap when
// RX_DATA_0 changes between consecutive sample cycles or reads 8'h00/8'hFF.
// -----------------------------------------------------------------------------
module bclk_train_seq #(
  parameter int TAP_MAX       = 127,
  parameter int SETTLE_CYCLES = 8,
  parameter int SAMPLE_CYCLES = 16,
  parameter int MIN_WINDOW    = 4
) (
  input  logic       FAB_CLK,
  input  logic       ARST_N,
  input  logic       TRAIN_START,
  output logic       TRAIN_BUSY,
  output logic       TRAIN_DONE,
  output logic       TRAIN_ERR,
  output logic [7:0] TAP_CENTER,
  output logic [8:0] WINDOW_WIDTH,
  output logic       DELAY_LINE_MOVE_0,
  output logic       DELAY_LINE_DIRECTION_0,
  output logic       DELAY_LINE_LOAD_0,
  output logic       EYE_MONITOR_CLEAR_FLAGS_0,
  input  logic       EYE_MONITOR_EARLY_0,
  input  logic       EYE_MONITOR_LATE_0,
  input  logic       DELAY_LINE_OUT_OF_RANGE_0,
  input  logic [7:0] RX_DATA_0
);

  localparam int CNT_W = 16;

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_CLEAR, S_SETTLE, S_SAMPLE, S_EVAL, S_STEP,
    S_FINISH, S_CLOAD, S_CMOVE, S_CGAP, S_DONE, S_ERR
  } state_t;

  state_t             r_state, w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [7:0]         r_tap;
  logic               r_fail;
  logic [7:0]         r_run_start, r_best_start;
  logic [8:0]         r_run_len, r_best_len;
  logic [7:0]         r_move_cnt;
  logic [7:0]         r_tap_center;
  logic [8:0]         r_window_width;
  logic               r_busy, r_done, r_err;
  logic               r_move, r_load, r_clr;

  logic               w_settle_end, w_sample_end, w_sweep_end;
  logic               w_run_better;
  logic [7:0]         w_fin_start;
  logic [8:0]         w_fin_len;
  logic [7:0]         w_center;
  logic               w_rx_bad;
  logic               w_tap_fail;

  assign w_settle_end = (r_cnt == CNT_W'(SETTLE_CYCLES - 1));
  assign w_sample_end = (r_cnt == CNT_W'(SAMPLE_CYCLES - 1));
  // Out-of-range is looked at only here, so a rise during SAMPLE cannot
  // disturb the current tap's result.
  assign w_sweep_end  = (r_tap == 8'(TAP_MAX)) || DELAY_LINE_OUT_OF_RANGE_0;

  // Strictly greater: on equal lengths the earlier window is kept.
  assign w_run_better = (r_run_len > r_best_len);
  assign w_fin_start  = w_run_better ? r_run_start : r_best_start;
  assign w_fin_len    = w_run_better ? r_run_len   : r_best_len;
  assign w_center     = 8'({1'b0, w_fin_start} + ((w_fin_len - 9'd1) >> 1));

`ifdef BCLK_TRAIN_RXDATA_CHECK_EN
  logic [7:0] r_prev_rx;
  // r_cnt is 0 on the first sample cycle, where there is no previous value.
  assign w_rx_bad = (RX_DATA_0 == 8'h00) || (RX_DATA_0 == 8'hFF) ||
                    ((r_cnt != '0) && (RX_DATA_0 != r_prev_rx));

  always_ff @(posedge FAB_CLK or negedge ARST_N) begin
    if (!ARST_N)                r_prev_rx <= 8'h00;
    else if (r_state == S_SAMPLE) r_prev_rx <= RX_DATA_0;
  end
`else
  logic w_rx_unused;
  assign w_rx_unused = ^RX_DATA_0;
  assign w_rx_bad    = 1'b0;
`endif

  assign w_tap_fail = EYE_MONITOR_EARLY_0 | EYE_MONITOR_LATE_0 | w_rx_bad;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge FAB_CLK or negedge ARST_N) begin
    if (!ARST_N) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // NOTE: w_next gets its default before the case so no path leaves it
  // unassigned, which would infer a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERR: if (TRAIN_START) w_next = S_LOAD;
      S_LOAD:   w_next = S_CLEAR;
      S_CLEAR:  w_next = S_SETTLE;
      S_SETTLE: if (w_settle_end) w_next = S_SAMPLE;
      S_SAMPLE: if (w_sample_end) w_next = S_EVAL;
      S_EVAL:   w_next = S_STEP;
      S_STEP:   w_next = w_sweep_end ? S_FINISH : S_CLEAR;
      S_FINISH: w_next = (w_fin_len < 9'(MIN_WINDOW)) ? S_ERR : S_CLOAD;
      S_CLOAD:  w_next = (r_tap_center == 8'd0) ? S_DONE : S_CMOVE;
      S_CMOVE:  w_next = S_CGAP;
      S_CGAP:   w_next = (r_move_cnt == r_tap_center) ? S_DONE : S_CMOVE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Sweep datapath.
  always_ff @(posedge FAB_CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      r_cnt          <= '0;
      r_tap          <= 8'd0;
      r_fail         <= 1'b0;
      r_run_start    <= 8'd0;
      r_run_len      <= 9'd0;
      r_best_start   <= 8'd0;
      r_best_len     <= 9'd0;
      r_move_cnt     <= 8'd0;
      r_tap_center   <= 8'd0;
      r_window_width <= 9'd0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE, S_ERR: begin
          if (TRAIN_START) begin
            r_tap        <= 8'd0;
            r_run_start  <= 8'd0;
            r_run_len    <= 9'd0;
            r_best_start <= 8'd0;
            r_best_len   <= 9'd0;
          end
        end
        S_LOAD: begin
          r_tap <= 8'd0;
          r_cnt <= '0;
        end
        S_CLEAR: begin
          r_fail <= 1'b0;
          r_cnt  <= '0;
        end
        S_SETTLE: r_cnt <= w_settle_end ? '0 : r_cnt + 1'b1;
        S_SAMPLE: begin
          r_cnt  <= w_sample_end ? '0 : r_cnt + 1'b1;
          r_fail <= r_fail | w_tap_fail;
        end
        S_EVAL: begin
          if (!r_fail) begin
            if (r_run_len == 9'd0) r_run_start <= r_tap;
            r_run_len <= r_run_len + 9'd1;
          end else begin
            if (w_run_better) begin
              r_best_start <= r_run_start;
              r_best_len   <= r_run_len;
            end
            r_run_len <= 9'd0;
          end
        end
        S_STEP: if (!w_sweep_end) r_tap <= r_tap + 8'd1;
        S_FINISH: begin
          r_best_start   <= w_fin_start;
          r_best_len     <= w_fin_len;
          r_run_len      <= 9'd0;
          r_window_width <= w_fin_len;
          r_tap_center   <= (w_fin_len < 9'(MIN_WINDOW)) ? 8'd0 : w_center;
        end
        S_CLOAD: r_move_cnt <= 8'd0;
        S_CMOVE: r_move_cnt <= r_move_cnt + 8'd1;
        default: ;
      endcase
    end
  end

  // Registered status and IOD pulses, decoded from the next state so each
  // pulse is high during the cycle its state is occupied. The sweep step is
  // issued during the CLEAR that follows STEP; settle time covers both.
  always_ff @(posedge FAB_CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
      r_move <= 1'b0;
      r_load <= 1'b0;
      r_clr  <= 1'b0;
    end else begin
      r_busy <= !(w_next inside {S_IDLE, S_DONE, S_ERR});
      r_done <= (w_next == S_DONE);
      r_err  <= (w_next == S_ERR);
      r_move <= (w_next == S_CMOVE) || ((r_state == S_STEP) && (w_next == S_CLEAR));
      r_load <= (w_next == S_LOAD) || (w_next == S_CLOAD);
      r_clr  <= (w_next == S_CLEAR);
    end
  end

  assign TRAIN_BUSY                = r_busy;
  assign TRAIN_DONE                = r_done;
  assign TRAIN_ERR                 = r_err;
  assign TAP_CENTER                = r_tap_center;
  assign WINDOW_WIDTH              = r_window_width;
  assign DELAY_LINE_MOVE_0         = r_move;
  assign DELAY_LINE_DIRECTION_0    = 1'b1;
  assign DELAY_LINE_LOAD_0         = r_load;
  assign EYE_MONITOR_CLEAR_FLAGS_0 = r_clr;

endmodule
